cavlc_level_encoder: RTL
========================

// Module: cavlc_level_encoder
// PURPOSE
//  CAVLC level encoder; inverse of the CAVLC level decoder. Per 4x4 block it takes signed levels
//  in decode order, emits H.264 level_prefix/level_suffix codewords with suffixLength adaptation,
//  and packs them MSB-first into 16-bit BitstreamData words. Output drives the decoder's
//  BitstreamData/RdReq pins directly; used as bench stimulus source and encode-path block.
// PARAMETERS
//  LEVEL_W    13   level width, two's complement (matches decoder LevelOut)
//  WORD_W     16   output word width
//  ACC_W      48   packing accumulator width (>= WORD_W + 28 + 4)
// PORTS
//  Clk            in   1       clock
//  Reset          in   1       synchronous, active-high reset
//  LevelIn        in   LEVEL_W signed level, nonzero, non-trailing-one
//  LevelValid     in   1       LevelIn valid; transfer on LevelValid && LevelRdy
//  LevelRdy       out  1       encoder accepts a level this cycle
//  LevelFirst     in   1       first level of block (qualified by transfer)
//  SuffixInit     in   1       initial suffixLength (0/1) for block; sampled with LevelFirst
//  T1sLt3         in   1       TrailingOnes<3 for block; sampled with LevelFirst
//  LevelLast      in   1       last level of block
//  Flush          in   1       pulse: zero-pad pending bits to word boundary (slice end)
//  BitstreamData  out  WORD_W  packed bitstream word, first bit at [15]
//  WordValid      out  1       BitstreamData valid
//  RdReq          in   1       consumer pops word; pop on WordValid && RdReq
//  BlockDone      out  1       1-cycle pulse: last level's codeword entered accumulator
//  LevelErr       out  1       sticky: level unencodable (escape suffix >= 4096)
// BEHAVIOUR
//  Reset: LevelRdy=0 during Reset, 1 the cycle after; WordValid=0, BitstreamData=0, BlockDone=0,
//   LevelErr=0, fill=0, suffixLength=0, codeword stage empty. Reset mid-block discards all state.
//  Stage E (encode, 1 cycle): levelCode = L>0 ? 2L-2 : -2L-1; if LevelFirst && T1sLt3: -= 2.
//   sl = LevelFirst ? SuffixInit : current suffixLength.
//   sl==0: lc<14 -> prefix=lc, no suffix; lc<30 -> prefix=14, 4b suffix lc-14;
//          else prefix=15, 12b suffix lc-30.
//   sl>0:  lc<(15<<sl) -> prefix=lc>>sl, sl-bit suffix lc[sl-1:0];
//          else prefix=15, 12b suffix lc-(15<<sl).
//   codeword = prefix zeros, '1', suffix; len = prefix+1+suffixBits (1..28).
//   Escape suffix >= 4096: no codeword, LevelErr set (sticky), adaptation still applied.
//  Adaptation after each level, in order: if sl==0 sl=1; then if |L|>(3<<(sl-1)) && sl<6 sl++.
//  Stage P (pack): codeword appended below current fill bits; fill 0..ACC_W.
//   WordValid = fill>=16; pop removes top 16 bits; append and pop may occur in the same cycle.
//  LevelRdy = !Reset && fill<=20 && (stage E empty || it drains this cycle); no bits ever lost.
//  Latency: level accepted cycle N -> codeword in accumulator N+2; WordValid earliest N+2.
//  BlockDone pulses in cycle the LevelLast codeword (or its error drop) is appended.
//  Flush: after stage E drains, if fill%16!=0 pad zeros to next multiple; fill==0 -> no-op.
//   Levels presented during pending flush are held off (LevelRdy=0) until padding done.
//  LevelValid && LevelFirst while mid-block: new block starts; no error.
// STRUCTURE
//  cavlc_pkg: LEVEL_W, WORD_W, MAX_CW_LEN=28, SL_MAX=6, ESC_SUFFIX_W=12,
//   typedef struct packed {logic [27:0] bits; logic [4:0] len;} cavlc_cw_t.
//  Top holds stage E + suffixLength FSM; sub-module cavlc_bit_packer (accumulator, fill
//  counter, flush padding, WordValid/RdReq handshake), reusable by coeff_token encoder.
// TESTING
//  SuffixInit=0,T1sLt3=0: +1,-1,+2 then Flush -> bits 1|11|010, word 0xE800, 3 BlockDone=1 on +2.
//  T1sLt3=1, LevelFirst level +2 -> levelCode 0 -> single bit '1'; next +2 uses sl=1 -> '010'.
//  sl=0: +8 -> 19b (14 zeros,1,0000); +16 -> 28b (15 zeros,1,12 zeros); fill accounting exact.
//  SuffixInit=1: levels 4,7,13,25,49,97 -> sl 1->2->3->4->5->6, stays 6 on next 200.
//  sl=0 level -4095 -> LevelErr=1, no bits appended, BlockDone still pulses if LevelLast.
//  RdReq=0, stream 28b codewords -> LevelRdy drops at fill>20, words resume intact on RdReq=1;
//   Reset mid-stream -> WordValid=0 next cycle, next block encodes from sl=SuffixInit.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared constants and types for the CAVLC encode path.
package cavlc_pkg;
    localparam int LEVEL_W      = 13;
    localparam int WORD_W       = 16;
    localparam int ACC_W        = 48;
    localparam int MAX_CW_LEN   = 28;
    localparam int SL_MAX       = 6;
    localparam int ESC_SUFFIX_W = 12;
    localparam int FILL_W       = $clog2(ACC_W + 1);
    // A new level may only enter while a worst-case codeword still fits
    // behind whatever is in flight.
    localparam int FILL_RDY_MAX = 20;

    typedef struct packed {
        logic [MAX_CW_LEN-1:0] bits;   // right-aligned codeword
        logic [4:0]            len;    // 0 means "nothing to append"
    } cavlc_cw_t;

    typedef enum logic {ST_RUN, ST_FLUSH} flush_state_t;
endpackage

// File: rtl/cavlc_bit_packer.sv
// MSB-first bit packer: appends variable-length codewords below the current
// fill, hands out 16-bit words from the top, and zero-pads on flush.
module cavlc_bit_packer
    import cavlc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MAX_CW_LEN-1:0] cw_bits,
    input  logic [4:0]            cw_len,
    input  logic                  cw_valid,
    output logic                  cw_rdy,
    input  logic                  flush_req,
    input  logic                  rd_req,
    output logic [WORD_W-1:0]     data,
    output logic                  word_valid,
    output logic [FILL_W-1:0]     fill
);
    localparam int SUM_W = FILL_W + 1;

    logic [ACC_W-1:0] acc, acc_pop, acc_next;
    logic [SUM_W-1:0] fill_pop, fill_app, fill_pad, fill_next, shamt;
    logic             pop, app;

    assign word_valid = fill >= FILL_W'(WORD_W);
    assign data       = acc[ACC_W-1 -: WORD_W];

    // Pop first, then append into the freed space, then optional padding.
    always_comb begin
        pop      = word_valid && rd_req;
        acc_pop  = pop ? (acc << WORD_W) : acc;
        fill_pop = pop ? (SUM_W'(fill) - SUM_W'(WORD_W)) : SUM_W'(fill);
        cw_rdy   = (fill_pop + SUM_W'(cw_len)) <= SUM_W'(ACC_W);
        app      = cw_valid && cw_rdy && (cw_len != 5'd0);
        shamt    = SUM_W'(ACC_W) - fill_pop - SUM_W'(cw_len);
        acc_next = acc_pop;
        fill_app = fill_pop;
        if (app) begin
            acc_next = acc_pop | ({{(ACC_W-MAX_CW_LEN){1'b0}}, cw_bits} << shamt);
            fill_app = fill_pop + SUM_W'(cw_len);
        end
        // Bits below the fill are always zero, so padding is just a round-up.
        fill_pad  = (fill_app + SUM_W'(WORD_W - 1)) & ~SUM_W'(WORD_W - 1);
        fill_next = flush_req ? fill_pad : fill_app;
    end

    // Accumulator and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next[FILL_W-1:0];
        end
    end
endmodule

// File: rtl/cavlc_level_encoder.sv
// CAVLC level encoder: level -> level_prefix/level_suffix codeword with
// suffixLength adaptation, one-entry encode stage, and bit packing.
module cavlc_level_encoder
    import cavlc_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic [LEVEL_W-1:0] LevelIn,
    input  logic               LevelValid,
    output logic               LevelRdy,
    input  logic               LevelFirst,
    input  logic               SuffixInit,
    input  logic               T1sLt3,
    input  logic               LevelLast,
    input  logic               Flush,
    output logic [WORD_W-1:0]  BitstreamData,
    output logic               WordValid,
    input  logic               RdReq,
    output logic               BlockDone,
    output logic               LevelErr
);
    localparam int LC_W = LEVEL_W + 2;

    flush_state_t      state, state_next;
    logic              flush_req;
    logic [2:0]        sl_q, sl_use, sl_next;
    logic              neg;
    logic [LEVEL_W:0]  abs_l;
    logic [LC_W-1:0]   lc, thr, suffix;
    logic [3:0]        prefix, sbits;
    logic              esc_err;
    cavlc_cw_t         cw_enc, e_cw;
    logic              e_valid, e_last;
    logic              cw_rdy, accept;
    logic [FILL_W-1:0] fill;

    // Map level to levelCode, split into prefix/suffix, and compute the next suffixLength.
    always_comb begin
        neg   = LevelIn[LEVEL_W-1];
        abs_l = neg ? ('0 - {LevelIn[LEVEL_W-1], LevelIn}) : {1'b0, LevelIn};
        lc    = {abs_l, 1'b0} - (neg ? LC_W'(1) : LC_W'(2));
        if (LevelFirst && T1sLt3 && lc >= LC_W'(2))
            lc = lc - LC_W'(2);
        sl_use = LevelFirst ? {2'b00, SuffixInit} : sl_q;
        thr    = LC_W'(15) << sl_use;
        prefix = 4'd0;
        sbits  = 4'd0;
        suffix = '0;
        if (sl_use == 3'd0) begin
            if (lc < LC_W'(14)) begin
                prefix = lc[3:0];
            end else if (lc < LC_W'(30)) begin
                prefix = 4'd14;
                sbits  = 4'd4;
                suffix = lc - LC_W'(14);
            end else begin
                prefix = 4'd15;
                sbits  = 4'(ESC_SUFFIX_W);
                suffix = lc - LC_W'(30);
            end
        end else begin
            if (lc < thr) begin
                prefix = 4'(lc >> sl_use);
                sbits  = {1'b0, sl_use};
                suffix = lc & ((LC_W'(1) << sl_use) - LC_W'(1));
            end else begin
                prefix = 4'd15;
                sbits  = 4'(ESC_SUFFIX_W);
                suffix = lc - thr;
            end
        end
        // Only the escape branch uses a 12-bit suffix, so this flags overflow there only.
        esc_err     = (sbits == 4'(ESC_SUFFIX_W)) && (suffix >= LC_W'(1 << ESC_SUFFIX_W));
        cw_enc.bits = (MAX_CW_LEN'(1) << sbits) | MAX_CW_LEN'(suffix[ESC_SUFFIX_W-1:0]);
        cw_enc.len  = 5'(prefix) + 5'(sbits) + 5'd1;

        sl_next = (sl_use == 3'd0) ? 3'd1 : sl_use;
        if (sl_next < 3'(SL_MAX) && {1'b0, abs_l} > (LC_W'(3) << (sl_next - 3'd1)))
            sl_next = sl_next + 3'd1;
    end

    assign LevelRdy = !Reset && (fill <= FILL_W'(FILL_RDY_MAX)) &&
                      (!e_valid || cw_rdy) && (state == ST_RUN) && !Flush;
    assign accept   = LevelValid && LevelRdy;

    // Encode stage register, suffixLength state, sticky error and block-done pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            e_valid   <= 1'b0;
            e_last    <= 1'b0;
            e_cw      <= '0;
            sl_q      <= 3'd0;
            LevelErr  <= 1'b0;
            BlockDone <= 1'b0;
        end else begin
            BlockDone <= e_valid && cw_rdy && e_last;
            if (accept) begin
                e_valid <= 1'b1;
                e_last  <= LevelLast;
                // An unencodable level travels as a zero-length entry so BlockDone still fires.
                e_cw    <= esc_err ? '0 : cw_enc;
                sl_q    <= sl_next;
                if (esc_err)
                    LevelErr <= 1'b1;
            end else if (e_valid && cw_rdy) begin
                e_valid <= 1'b0;
            end
        end
    end

    // Flush state register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_RUN;
        else       state <= state_next;
    end

    // Flush sequencing: hold off levels, wait for the encode stage to drain, then pad once.
    always_comb begin
        state_next = state;
        flush_req  = 1'b0;
        case (state)
            ST_RUN:   if (Flush) state_next = ST_FLUSH;
            ST_FLUSH: if (!e_valid) begin
                flush_req  = 1'b1;
                state_next = ST_RUN;
            end
            default:  state_next = ST_RUN;
        endcase
    end

    cavlc_bit_packer u_packer (
        .clk        (Clk),
        .rst        (Reset),
        .cw_bits    (e_cw.bits),
        .cw_len     (e_cw.len),
        .cw_valid   (e_valid),
        .cw_rdy     (cw_rdy),
        .flush_req  (flush_req),
        .rd_req     (RdReq),
        .data       (BitstreamData),
        .word_valid (WordValid),
        .fill       (fill)
    );
endmodule
